mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter FIXED_PRIO, default 0: 0 = round-robin between ports; 1 = data port always wins.
REQ-002 SHALL have port clk, input, 1: single clock; all state is updated on the rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have inst-port inputs: inst_req (1, fetch request) and inst_addr (32, byte address).
REQ-005 SHALL have inst-port outputs: inst_addr_ok (1, request accepted this cycle), inst_data_ok (1, response valid) and inst_rdata (32, read data).
REQ-006 SHALL have data-port inputs: data_req (1), data_wr (1, 1 = write) and data_wstrb (4, byte enables).
REQ-007 SHALL have data-port inputs data_addr (32) and data_wdata (32).
REQ-008 SHALL have data-port outputs: data_addr_ok (1), data_data_ok (1) and data_rdata (32).
REQ-009 SHALL have RAM-side outputs: ram_en (1), ram_we (4), ram_addr (32) and ram_wdata (32).
REQ-010 SHALL have RAM-side input ram_rdata (32); the RAM is synchronous, single-port, with one-cycle read latency.

Function
REQ-011 SHALL accept at most one request per cycle; acceptance = req high and the matching addr_ok high in the same cycle.
REQ-012 SHALL generate inst_addr_ok and data_addr_ok combinationally from the current-cycle requests and the arbitration state; both SHALL never be high together.
REQ-013 SHALL raise addr_ok for a port only when that port's req is high.
REQ-014 SHALL grant the sole requester when only one port requests.
REQ-015 SHALL, with both requesting and FIXED_PRIO=0, grant the port not granted at the last accepted request (register last_gnt: 0 = inst, 1 = data).
REQ-016 SHALL, with both requesting and FIXED_PRIO=1, grant data.
REQ-017 SHALL update last_gnt only on an accepted request.
REQ-018 SHALL, in the accept cycle N, drive ram_en=1, ram_addr = the granted address and ram_wdata = data_wdata.
REQ-019 SHALL drive ram_we = data_wstrb only for a granted data write, and 4'b0 otherwise (including all inst requests).
REQ-020 SHALL, with no accept, drive ram_en=0, ram_we=0, ram_addr=0 and ram_wdata=0.
REQ-021 SHALL register resp_valid and resp_owner at the end of cycle N.
REQ-022 SHALL pulse the owner's data_ok for exactly one cycle in cycle N+1; rdata = ram_rdata in that cycle.
REQ-023 SHALL drive the non-owner's rdata, and any rdata while data_ok is low, to 32'h0.
REQ-024 SHALL give a data write a data_ok pulse in N+1 with data_rdata = 32'h0.
REQ-025 SHALL be fully pipelined: a new request may be accepted in N+1 while the response from N is returned, sustaining 1 request per cycle.
REQ-026 SHALL apply no response backpressure; each requester captures rdata in its data_ok cycle.
REQ-027 SHALL keep responses in acceptance order per port; each accept yields exactly one data_ok, with none lost or duplicated.
REQ-028 SHALL expect a requester to hold req/addr/wr/wstrb/wdata stable until accepted; a request dropped before acceptance is never issued.
REQ-029 SHALL not register the address; the RAM address is combinational from the granted port.

Reset
REQ-030 SHALL, on reset high, immediately clear resp_valid, set resp_owner=0 and set last_gnt=1, so inst wins the first contention after reset.
REQ-031 SHALL hold all addr_ok, data_ok, ram_en and ram_we at 0 while reset is high.
REQ-032 SHALL, if reset asserts while a response is pending, cancel that response so that no data_ok ever appears for it.
REQ-033 SHALL accept requests from the first rising edge after reset deasserts.

Verification
REQ-034 SHALL cover: inst_req only, addr 0x1c000000, RAM returns 0x02800413 -> N: inst_addr_ok=1, ram_en=1, ram_we=0; N+1: inst_data_ok=1, inst_rdata=0x02800413.
REQ-035 SHALL cover: both requesting continuously for 6 cycles, FIXED_PRIO=0 -> grants I,D,I,D,I,D; one data_ok per cycle from N+1, owners matching.
REQ-036 SHALL cover: FIXED_PRIO=1, both requesting for 3 cycles -> data granted every cycle and inst_addr_ok stays 0.
REQ-037 SHALL cover: data write, addr 0x100, wdata 0xdeadbeef, wstrb 4'b0011 -> ram_we=4'b0011, ram_wdata=0xdeadbeef; data_data_ok in N+1 with data_rdata=0.
REQ-038 SHALL cover: reset pulse mid-cycle after an inst accept -> outputs 0 immediately, no inst_data_ok; after release, contention grants inst first.
REQ-039 SHALL cover: back-to-back inst reads of 0x0, 0x4, 0x8 -> addr_ok 3 cycles consecutively; data_ok in the next 3 cycles with RAM data in order.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: instruction/data requester ports and the RAM-side bus of the two-port memory arbiter.
// slave is the arbiter's view; master is the requesters-plus-RAM view.
interface mem_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    modport slave (
        input  inst_req, inst_addr, data_req, data_wr, data_wstrb, data_addr, data_wdata, ram_rdata,
        output inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata
    );
    modport master (
        output inst_req, inst_addr, data_req, data_wr, data_wstrb, data_addr, data_wdata, ram_rdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous single-port RAM between an instruction and a data port,
// one accept per cycle, fully pipelined, responses returned exactly one cycle after acceptance.
module mem_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    logic last_gnt_q, last_gnt_d;
    logic resp_valid_q, resp_valid_d;
    logic resp_owner_q, resp_owner_d;
    logic resp_wr_q, resp_wr_d;
    logic accept, gnt_data;
    always_comb begin
        // data wins when alone, under fixed priority, or when inst took the last accepted slot
        gnt_data          = bus.data_req & (~bus.inst_req | FIXED_PRIO | ~last_gnt_q);
        accept            = ~reset & (bus.inst_req | bus.data_req);
        bus.inst_addr_ok  = accept & ~gnt_data;
        bus.data_addr_ok  = accept & gnt_data;
        bus.ram_en        = accept;
        bus.ram_we        = (bus.data_addr_ok & bus.data_wr) ? bus.data_wstrb : 4'b0;
        bus.ram_addr      = !accept ? 32'h0 : gnt_data ? bus.data_addr : bus.inst_addr;
        bus.ram_wdata     = accept ? bus.data_wdata : 32'h0;
        resp_valid_d      = accept;
        resp_owner_d      = accept & gnt_data;
        resp_wr_d         = bus.data_addr_ok & bus.data_wr;
        last_gnt_d        = accept ? gnt_data : last_gnt_q;
        bus.inst_data_ok  = resp_valid_q & ~resp_owner_q;
        bus.data_data_ok  = resp_valid_q & resp_owner_q;
        bus.inst_rdata    = bus.inst_data_ok ? bus.ram_rdata : 32'h0;
        bus.data_rdata    = (bus.data_data_ok & ~resp_wr_q) ? bus.ram_rdata : 32'h0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            resp_owner_q <= 1'b0;
            resp_wr_q    <= 1'b0;
            last_gnt_q   <= 1'b1;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_owner_q <= resp_owner_d;
            resp_wr_q    <= resp_wr_d;
            last_gnt_q   <= last_gnt_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: drives a round-robin and a fixed-priority arbiter with the same requests and checks
// both every cycle against a grant/response reference model with its own shadow copy of the RAM.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        ireq, dreq, dwr;
    logic [31:0] iaddr, daddr, dwdata;
    logic [3:0]  dwstrb;
    logic [31:0] rd0, rd1;

    mem_arbiter_if b0();
    mem_arbiter_if b1();
    mem_arbiter #(.FIXED_PRIO(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(b0.slave));
    mem_arbiter #(.FIXED_PRIO(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));

    assign b0.inst_req = ireq;  assign b0.inst_addr = iaddr;
    assign b0.data_req = dreq;  assign b0.data_wr = dwr;  assign b0.data_wstrb = dwstrb;
    assign b0.data_addr = daddr; assign b0.data_wdata = dwdata; assign b0.ram_rdata = rd0;
    assign b1.inst_req = ireq;  assign b1.inst_addr = iaddr;
    assign b1.data_req = dreq;  assign b1.data_wr = dwr;  assign b1.data_wstrb = dwstrb;
    assign b1.data_addr = daddr; assign b1.data_wdata = dwdata; assign b1.ram_rdata = rd1;

    function automatic logic [31:0] init_word(input int i);
        return (i == 0) ? 32'h02800413 : 32'(i) * 32'h9E3779B1 + 32'h1234;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // RAM models: sample the request at the falling edge, act on the rising edge, one-cycle read latency
    logic [31:0] mem0 [256];
    logic [31:0] mem1 [256];
    initial begin
        logic e0, e1;
        logic [7:0] a0, a1;
        logic [3:0] w0, w1;
        logic [31:0] d0, d1;
        for (int i = 0; i < 256; i++) begin
            mem0[i] = init_word(i);
            mem1[i] = init_word(i);
        end
        forever begin
            @(negedge clk);
            e0 = b0.ram_en; a0 = b0.ram_addr[9:2]; w0 = b0.ram_we; d0 = b0.ram_wdata;
            e1 = b1.ram_en; a1 = b1.ram_addr[9:2]; w1 = b1.ram_we; d1 = b1.ram_wdata;
            @(posedge clk);
            if (e0) begin rd0 <= mem0[a0]; mem0[a0] = merge(mem0[a0], d0, w0); end
            if (e1) begin rd1 <= mem1[a1]; mem1[a1] = merge(mem1[a1], d1, w1); end
        end
    end

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // reference model: g = 0 none, 1 inst, 2 data; pending response described per instance
    int          gk [2];
    logic        lg [2];
    logic        pv [2], po [2], pw [2];
    logic [31:0] pdat [2];
    logic [31:0] sh [2][256];

    task automatic check_and_commit();
        for (int k = 0; k < 2; k++) begin
            int g;
            logic [6:0] og;
            logic [63:0] ora;
            logic [65:0] ors;
            logic ido, ddo;
            logic [31:0] ea;
            if (reset || !(ireq || dreq)) g = 0;
            else if (!dreq) g = 1;
            else if (!ireq) g = 2;
            else if (k == 1) g = 2;
            else g = lg[k] ? 1 : 2;
            gk[k] = g;
            ea = (g == 1) ? iaddr : (g == 2) ? daddr : 32'h0;
            ido = pv[k] && !po[k];
            ddo = pv[k] && po[k];
            if (k == 0) begin
                og  = {b0.inst_addr_ok, b0.data_addr_ok, b0.ram_en, b0.ram_we};
                ora = {b0.ram_addr, b0.ram_wdata};
                ors = {b0.inst_data_ok, b0.inst_rdata, b0.data_data_ok, b0.data_rdata};
            end else begin
                og  = {b1.inst_addr_ok, b1.data_addr_ok, b1.ram_en, b1.ram_we};
                ora = {b1.ram_addr, b1.ram_wdata};
                ors = {b1.inst_data_ok, b1.inst_rdata, b1.data_data_ok, b1.data_rdata};
            end
            chk($sformatf("dut%0d_grant_c%0d", k, cyc), 128'(og),
                128'({g == 1, g == 2, g != 0, (g == 2 && dwr) ? dwstrb : 4'b0}));
            chk($sformatf("dut%0d_ram_c%0d", k, cyc), 128'(ora), 128'({ea, (g != 0) ? dwdata : 32'h0}));
            chk($sformatf("dut%0d_resp_c%0d", k, cyc), 128'(ors),
                128'({ido, ido ? pdat[k] : 32'h0, ddo, (ddo && !pw[k]) ? pdat[k] : 32'h0}));
            if (reset) begin
                pv[k] = 1'b0;
                lg[k] = 1'b1;
            end else begin
                pv[k] = (g != 0);
                po[k] = (g == 2);
                pw[k] = (g == 2) && dwr;
                pdat[k] = sh[k][ea[9:2]];
                if (pw[k]) sh[k][ea[9:2]] = merge(sh[k][ea[9:2]], dwdata, dwstrb);
                if (g != 0) lg[k] = (g == 2);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_and_commit();
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] t;
        for (int k = 0; k < 2; k++) begin
            lg[k] = 1'b1; pv[k] = 1'b0; po[k] = 1'b0; pw[k] = 1'b0; pdat[k] = 32'h0;
            for (int i = 0; i < 256; i++) sh[k][i] = init_word(i);
        end
        reset = 1'b1;
        ireq = 1'b1; dreq = 1'b1; dwr = 1'b0; dwstrb = 4'hf;
        iaddr = 32'h40; daddr = 32'h80; dwdata = 32'h11223344;
        step();
        step();
        reset = 1'b0;
        // continuous contention: round robin alternates from inst, fixed priority always picks data
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("rr_inst_grant_%0d", c), 128'(b0.inst_addr_ok), 128'(c % 2 == 0));
            chk($sformatf("fp_no_inst_%0d", c), 128'(b1.inst_addr_ok), 128'(0));
            chk($sformatf("fp_data_%0d", c), 128'(b1.data_addr_ok), 128'(1));
            step();
            if (gk[0] == 1) iaddr = iaddr + 32'h4;
            else daddr = daddr + 32'h4;
        end
        ireq = 1'b0; dreq = 1'b0;
        step();
        ireq = 1'b1; iaddr = 32'h1c000000;
        #1;
        chk("fetch_addr_ok", 128'({b0.inst_addr_ok, b0.ram_en, b0.ram_we}), 128'({1'b1, 1'b1, 4'b0}));
        step();
        ireq = 1'b0;
        #1;
        chk("fetch_data", 128'({b0.inst_data_ok, b0.inst_rdata}), 128'({1'b1, 32'h02800413}));
        step();
        dreq = 1'b1; dwr = 1'b1; daddr = 32'h100; dwdata = 32'hdeadbeef; dwstrb = 4'b0011;
        #1;
        chk("write_ram", 128'({b0.ram_we, b0.ram_wdata, b0.ram_addr}), 128'({4'b0011, 32'hdeadbeef, 32'h100}));
        step();
        dreq = 1'b0; dwr = 1'b0;
        #1;
        chk("write_resp", 128'({b0.data_data_ok, b0.data_rdata}), 128'({1'b1, 32'h0}));
        step();
        ireq = 1'b1;
        for (int i = 0; i < 3; i++) begin
            iaddr = 32'(4 * i);
            #1;
            chk($sformatf("b2b_addr_ok_%0d", i), 128'(b0.inst_addr_ok), 128'(1));
            step();
            #1;
            chk($sformatf("b2b_data_%0d", i), 128'({b0.inst_data_ok, b0.inst_rdata}), 128'({1'b1, init_word(i)}));
        end
        ireq = 1'b0;
        step();
        // reset while an inst response is pending: it must vanish and inst must win the next contention
        ireq = 1'b1; iaddr = 32'h20;
        step();
        dreq = 1'b1; daddr = 32'h24;
        #1 reset = 1'b1;
        #1;
        chk("rst_dut0_quiet", 128'({b0.inst_addr_ok, b0.data_addr_ok, b0.ram_en, b0.ram_we, b0.inst_data_ok, b0.data_data_ok}), 128'(0));
        chk("rst_dut1_quiet", 128'({b1.inst_addr_ok, b1.data_addr_ok, b1.ram_en, b1.ram_we, b1.inst_data_ok, b1.data_data_ok}), 128'(0));
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin pv[k] = 1'b0; lg[k] = 1'b1; end
        #1;
        chk("rst_inst_first", 128'({b0.inst_addr_ok, b0.data_addr_ok}), 128'(2'b10));
        step();
        for (int c = 0; c < 400; c++) begin
            if (!ireq || gk[0] == 1) begin
                t = $urandom;
                ireq = 1'($urandom_range(0, 1));
                iaddr = {t[31:10], 8'($urandom_range(0, 255)), 2'b00};
            end
            if (!dreq || gk[0] == 2) begin
                t = $urandom;
                dreq = 1'($urandom_range(0, 1));
                dwr = 1'($urandom_range(0, 1));
                dwstrb = 4'($urandom);
                dwdata = $urandom;
                daddr = {t[31:10], 8'($urandom_range(0, 31)), 2'b00};
            end
            step();
        end
        ireq = 1'b0; dreq = 1'b0;
        step();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
